// File: rtl/hazard_info_pipe.sv
// Hazard bookkeeping for a 5-stage pipeline: carries destination/Tnew records
// through E, M and W and derives the D- and E-stage operand forward selects.
module hazard_info_pipe #(
    parameter int TNEW_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              HIP_i_Stall,
    input  logic [4:0]        HIP_i_D_Rs,
    input  logic [4:0]        HIP_i_D_Rt,
    input  logic [4:0]        HIP_i_D_WAddr,
    input  logic [TNEW_W-1:0] HIP_i_D_Tnew,
    output logic [4:0]        HIP_o_E_WAddr,
    output logic [TNEW_W-1:0] HIP_o_E_Tnew,
    output logic [4:0]        HIP_o_M_WAddr,
    output logic [TNEW_W-1:0] HIP_o_M_Tnew,
    output logic [4:0]        HIP_o_W_WAddr,
    output logic [1:0]        HIP_o_D_FwdRs,
    output logic [1:0]        HIP_o_D_FwdRt,
    output logic [1:0]        HIP_o_E_FwdRs,
    output logic [1:0]        HIP_o_E_FwdRt
);

    logic [4:0]        e_rs_q, e_rs_d;
    logic [4:0]        e_rt_q, e_rt_d;
    logic [4:0]        e_waddr_q, e_waddr_d;
    logic [TNEW_W-1:0] e_tnew_q, e_tnew_d;
    logic [4:0]        m_waddr_q, m_waddr_d;
    logic [TNEW_W-1:0] m_tnew_q, m_tnew_d;
    logic [4:0]        w_waddr_q, w_waddr_d;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] n);
        logic [TNEW_W-1:0] r;
        if (n == {TNEW_W{1'b0}}) begin
            r = {TNEW_W{1'b0}};
        end else begin
            r = n - {{(TNEW_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // The youngest matching stage decides; a match whose result is not yet ready yields 0.
    function automatic logic [1:0] d_fwd(
        input logic [4:0]        r,
        input logic [4:0]        e_wa,
        input logic [TNEW_W-1:0] e_tn,
        input logic [4:0]        m_wa,
        input logic [TNEW_W-1:0] m_tn,
        input logic [4:0]        w_wa
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (r == 5'd0) begin
            sel = 2'd0;
        end else if (r == e_wa) begin
            sel = (e_tn == {TNEW_W{1'b0}}) ? 2'd1 : 2'd0;
        end else if (r == m_wa) begin
            sel = (m_tn == {TNEW_W{1'b0}}) ? 2'd2 : 2'd0;
        end else if (r == w_wa) begin
            sel = 2'd3;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    function automatic logic [1:0] e_fwd(
        input logic [4:0]        r,
        input logic [4:0]        m_wa,
        input logic [TNEW_W-1:0] m_tn,
        input logic [4:0]        w_wa
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (r == 5'd0) begin
            sel = 2'd0;
        end else if (r == m_wa) begin
            sel = (m_tn == {TNEW_W{1'b0}}) ? 2'd1 : 2'd0;
        end else if (r == w_wa) begin
            sel = 2'd2;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Next-state: E takes the D record or a bubble; M and W always advance.
    always_comb begin
        e_rs_d    = 5'd0;
        e_rt_d    = 5'd0;
        e_waddr_d = 5'd0;
        e_tnew_d  = {TNEW_W{1'b0}};
        if (HIP_i_Stall) begin
            e_rs_d    = 5'd0;
            e_rt_d    = 5'd0;
            e_waddr_d = 5'd0;
            e_tnew_d  = {TNEW_W{1'b0}};
        end else begin
            e_rs_d    = HIP_i_D_Rs;
            e_rt_d    = HIP_i_D_Rt;
            e_waddr_d = HIP_i_D_WAddr;
            e_tnew_d  = HIP_i_D_Tnew;
        end
        m_waddr_d = e_waddr_q;
        m_tnew_d  = sat_dec(e_tnew_q);
        w_waddr_d = m_waddr_q;
    end

    // Stage registers; reset wins over stall and flushes every record.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_rs_q    <= 5'd0;
            e_rt_q    <= 5'd0;
            e_waddr_q <= 5'd0;
            e_tnew_q  <= {TNEW_W{1'b0}};
            m_waddr_q <= 5'd0;
            m_tnew_q  <= {TNEW_W{1'b0}};
            w_waddr_q <= 5'd0;
        end else begin
            e_rs_q    <= e_rs_d;
            e_rt_q    <= e_rt_d;
            e_waddr_q <= e_waddr_d;
            e_tnew_q  <= e_tnew_d;
            m_waddr_q <= m_waddr_d;
            m_tnew_q  <= m_tnew_d;
            w_waddr_q <= w_waddr_d;
        end
    end

    assign HIP_o_E_WAddr = e_waddr_q;
    assign HIP_o_E_Tnew  = e_tnew_q;
    assign HIP_o_M_WAddr = m_waddr_q;
    assign HIP_o_M_Tnew  = m_tnew_q;
    assign HIP_o_W_WAddr = w_waddr_q;

    assign HIP_o_D_FwdRs = d_fwd(HIP_i_D_Rs, e_waddr_q, e_tnew_q, m_waddr_q, m_tnew_q, w_waddr_q);
    assign HIP_o_D_FwdRt = d_fwd(HIP_i_D_Rt, e_waddr_q, e_tnew_q, m_waddr_q, m_tnew_q, w_waddr_q);
    assign HIP_o_E_FwdRs = e_fwd(e_rs_q, m_waddr_q, m_tnew_q, w_waddr_q);
    assign HIP_o_E_FwdRt = e_fwd(e_rt_q, m_waddr_q, m_tnew_q, w_waddr_q);

endmodule

// File: tb/tb_hazard_info_pipe.sv
// Randomized bench for hazard_info_pipe against a stage-list reference model,
// plus directed scenarios for the pipeline corner cases.
module tb_hazard_info_pipe;

    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic [4:0]    d_rs, d_rt, d_wa;
    logic [TW-1:0] d_tn;
    logic [4:0]    e_wa, m_wa, w_wa;
    logic [TW-1:0] e_tn, m_tn;
    logic [1:0]    d_frs, d_frt, e_frs, e_frt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int rs;
        int rt;
        int wa;
        int tn;
    } rec_t;

    // Reference pipeline: index 0 = E, 1 = M, 2 = W; each keeps its Tnew as issued.
    rec_t st[3];

    hazard_info_pipe #(.TNEW_W(TW)) dut (
        .clk           (clk),
        .reset         (reset),
        .HIP_i_Stall   (stall),
        .HIP_i_D_Rs    (d_rs),
        .HIP_i_D_Rt    (d_rt),
        .HIP_i_D_WAddr (d_wa),
        .HIP_i_D_Tnew  (d_tn),
        .HIP_o_E_WAddr (e_wa),
        .HIP_o_E_Tnew  (e_tn),
        .HIP_o_M_WAddr (m_wa),
        .HIP_o_M_Tnew  (m_tn),
        .HIP_o_W_WAddr (w_wa),
        .HIP_o_D_FwdRs (d_frs),
        .HIP_o_D_FwdRt (d_frt),
        .HIP_o_E_FwdRs (e_frs),
        .HIP_o_E_FwdRt (e_frt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Remaining cycles until the result exists, for a record sitting in stage k.
    function automatic int tnew_at(int k);
        if (k == 0) return st[0].tn;
        if (k == 1) return (st[1].tn > 0) ? st[1].tn - 1 : 0;
        return 0;
    endfunction

    // Scan stages from the youngest; the first nonzero-destination match decides.
    function automatic int fwd_model(int r, int first);
        if (r == 0) return 0;
        for (int k = first; k < 3; k++) begin
            if (st[k].wa != 0 && st[k].wa == r)
                return (tnew_at(k) == 0) ? (k - first + 1) : 0;
        end
        return 0;
    endfunction

    task automatic set_d(input logic s, input int rs, input int rt, input int wa, input int tn);
        stall = s;
        d_rs  = 5'(rs);
        d_rt  = 5'(rt);
        d_wa  = 5'(wa);
        d_tn  = TW'(tn);
    endtask

    task automatic tick();
        rec_t nr;
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 3; k++) st[k] = '{0, 0, 0, 0};
        end else begin
            nr = stall ? '{0, 0, 0, 0} : '{int'(d_rs), int'(d_rt), int'(d_wa), int'(d_tn)};
            st[2] = st[1];
            st[1] = st[0];
            st[0] = nr;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".E_WAddr"}, int'(e_wa), st[0].wa);
        chk({tag, ".E_Tnew"},  int'(e_tn), tnew_at(0));
        chk({tag, ".M_WAddr"}, int'(m_wa), st[1].wa);
        chk({tag, ".M_Tnew"},  int'(m_tn), tnew_at(1));
        chk({tag, ".W_WAddr"}, int'(w_wa), st[2].wa);
        chk({tag, ".D_FwdRs"}, int'(d_frs), fwd_model(int'(d_rs), 0));
        chk({tag, ".D_FwdRt"}, int'(d_frt), fwd_model(int'(d_rt), 0));
        chk({tag, ".E_FwdRs"}, int'(e_frs), fwd_model(st[0].rs, 1));
        chk({tag, ".E_FwdRt"}, int'(e_frt), fwd_model(st[0].rt, 1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_d(1'b0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) st[k] = '{0, 0, 0, 0};
        reset = 1'b1;
        set_d(1'b0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        check_all("reset");
        chk("reset.E_WAddr0", int'(e_wa), 0);
        chk("reset.D_FwdRs0", int'(d_frs), 0);

        // Load-use chain
        set_d(1'b0, 0, 0, 8, 2);
        tick(); set_d(1'b0, 0, 0, 0, 0);
        chk("lw.E_Tnew", int'(e_tn), 2);
        check_all("lw1");
        tick();
        chk("lw.M_WAddr", int'(m_wa), 8);
        chk("lw.M_Tnew",  int'(m_tn), 1);
        tick();
        chk("lw.W_WAddr", int'(w_wa), 8);

        // Stall bubble while M and W keep moving
        do_reset();
        set_d(1'b0, 0, 0, 3, 0); tick();
        set_d(1'b0, 0, 0, 4, 0); tick();
        set_d(1'b1, 0, 0, 9, 1); tick();
        set_d(1'b0, 0, 0, 0, 0);
        chk("stall.E_WAddr", int'(e_wa), 0);
        chk("stall.E_Tnew",  int'(e_tn), 0);
        chk("stall.M_WAddr", int'(m_wa), 4);
        chk("stall.W_WAddr", int'(w_wa), 3);
        check_all("stall");

        // D forward priority and youngest-match stop
        do_reset();
        set_d(1'b0, 0, 0, 5, 0); tick();
        set_d(1'b0, 0, 0, 5, 0); tick();
        set_d(1'b0, 5, 0, 0, 0); #1;
        chk("dprio.FwdRs_E", int'(d_frs), 1);
        set_d(1'b0, 0, 0, 5, 1); tick();
        set_d(1'b0, 5, 0, 0, 0); #1;
        chk("dprio.FwdRs_stop", int'(d_frs), 0);
        check_all("dprio");

        // $0 guard with nonzero Tnew
        do_reset();
        set_d(1'b0, 0, 0, 0, 3); tick();
        set_d(1'b0, 0, 0, 0, 0); #1;
        chk("zero.D_FwdRs", int'(d_frs), 0);
        chk("zero.D_FwdRt", int'(d_frt), 0);
        chk("zero.E_FwdRs", int'(e_frs), 0);
        chk("zero.E_FwdRt", int'(e_frt), 0);

        // E forwarding from M then W
        do_reset();
        set_d(1'b0, 0, 0, 7, 0); tick();
        set_d(1'b0, 0, 7, 0, 0); tick();
        set_d(1'b0, 0, 0, 0, 0); #1;
        chk("efwd.FwdRt_M", int'(e_frt), 1);
        do_reset();
        set_d(1'b0, 0, 0, 7, 0); tick();
        set_d(1'b0, 0, 0, 0, 0); tick();
        set_d(1'b0, 0, 7, 0, 0); tick();
        set_d(1'b0, 0, 0, 0, 0); #1;
        chk("efwd.FwdRt_W", int'(e_frt), 2);

        // Mid-stream reset with all stages full, together with stall
        set_d(1'b0, 1, 2, 11, 3); tick();
        set_d(1'b0, 11, 11, 12, 0); tick();
        set_d(1'b0, 12, 12, 13, 1); tick();
        reset = 1'b1;
        set_d(1'b1, 0, 0, 14, 2);
        tick();
        reset = 1'b0;
        set_d(1'b0, 0, 0, 0, 0); #1;
        chk("midrst.E_WAddr", int'(e_wa), 0);
        chk("midrst.E_Tnew",  int'(e_tn), 0);
        chk("midrst.M_WAddr", int'(m_wa), 0);
        chk("midrst.M_Tnew",  int'(m_tn), 0);
        chk("midrst.W_WAddr", int'(w_wa), 0);
        chk("midrst.E_FwdRs", int'(e_frs), 0);
        chk("midrst.E_FwdRt", int'(e_frt), 0);

        // Randomized traffic over a small register range to provoke matches
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
            set_d(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            tick();
            reset = 1'b0;
            set_d(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_info_pipe.md
HAZARD_INFO_PIPE -- requirements
Module: hazard_info_pipe

Interface
REQ-001 SHALL have parameter TNEW_W, default 4, width of every Tnew field.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset, sampled at the rising edge of clk.
REQ-004 SHALL have port HIP_i_Stall  input  1  D-stage stall from the stall control unit.
REQ-005 SHALL have port HIP_i_D_Rs  input  5  rs index of the instruction in D.
REQ-006 SHALL have port HIP_i_D_Rt  input  5  rt index of the instruction in D.
REQ-007 SHALL have port HIP_i_D_WAddr  input  5  destination register of the D instruction; 0 means no write.
REQ-008 SHALL have port HIP_i_D_Tnew  input  TNEW_W  cycles until the D instruction's result exists, counted from E entry.
REQ-009 SHALL have ports HIP_o_E_WAddr (5) and HIP_o_E_Tnew (TNEW_W)  output  E-stage destination and Tnew.
REQ-010 SHALL have ports HIP_o_M_WAddr (5) and HIP_o_M_Tnew (TNEW_W)  output  M-stage destination and Tnew.
REQ-011 SHALL have port HIP_o_W_WAddr  output  5  W-stage destination.
REQ-012 SHALL have ports HIP_o_D_FwdRs and HIP_o_D_FwdRt  output  2  D-stage operand forward select.
REQ-013 SHALL have ports HIP_o_E_FwdRs and HIP_o_E_FwdRt  output  2  E-stage operand forward select.

Function
REQ-014 SHALL hold three registered stage records: E {Rs, Rt, WAddr, Tnew}, M {WAddr, Tnew}, W {WAddr}.
REQ-015 SHALL, with HIP_i_Stall=0, load E from HIP_i_D_Rs/Rt/WAddr/Tnew at each rising edge.
REQ-016 SHALL, with HIP_i_Stall=1, load E with a bubble (Rs=Rt=WAddr=0, Tnew=0); D-side inputs are discarded that cycle.
REQ-017 SHALL never freeze M or W; both advance every cycle regardless of stall.
REQ-018 SHALL load M.WAddr<=E.WAddr and M.Tnew<=sat_dec(E.Tnew), where sat_dec(0)=0 and sat_dec(n)=n-1.
REQ-019 SHALL load W.WAddr<=M.WAddr; no Tnew is kept for W (W is always 0).
REQ-020 SHALL drive the HIP_o_E_*, HIP_o_M_* and HIP_o_W_* outputs directly from the registers, with zero combinational latency.
REQ-021 SHALL compute HIP_o_D_FwdRs combinationally, first match wins: Rs==0 -> 0; Rs==E.WAddr and E.Tnew==0 -> 1; Rs==M.WAddr and M.Tnew==0 -> 2; Rs==W.WAddr -> 3; else 0.
REQ-022 SHALL stop the search at the youngest stage whose WAddr matches: if E matches with E.Tnew!=0, the result is 0 (stall covers it), not an older match.
REQ-023 SHALL apply the same rule to HIP_o_D_FwdRt using HIP_i_D_Rt.
REQ-024 SHALL compute HIP_o_E_FwdRs from E.Rs: E.Rs==0 -> 0; E.Rs==M.WAddr and M.Tnew==0 -> 1; E.Rs==W.WAddr -> 2; else 0, with the youngest-match rule of REQ-022 for M.
REQ-025 SHALL apply the same rule to HIP_o_E_FwdRt using E.Rt.
REQ-026 SHALL treat WAddr==0 as a non-match at every stage, even when the Tnew field is nonzero.
REQ-027 SHALL give simultaneous stall and reset reset priority.

Reset
REQ-028 SHALL clear all stage registers to 0 on a rising edge with reset=1: every WAddr, Tnew, Rs and Rt is 0.
REQ-029 SHALL hold all forward selects at 0 after reset until a nonzero-destination instruction reaches a stage.
REQ-030 SHALL, on reset asserted mid-stream, discard all in-flight records in that same edge; no record survives.

Verification
REQ-031 SHALL verify lw-use: D {WAddr=8, Tnew=2} with no stall. Next cycle E.Tnew=2; next cycle M.WAddr=8, M.Tnew=1; next cycle W.WAddr=8.
REQ-032 SHALL verify stall bubble: stall=1 with D {WAddr=9, Tnew=1}. Next cycle E={0,0,0,0}, while M and W still advance the previous records.
REQ-033 SHALL verify D forwarding priority: E {WAddr=5, Tnew=0}, M {WAddr=5, Tnew=0}, D Rs=5 -> HIP_o_D_FwdRs=1. Then with E.Tnew=1 -> 0.
REQ-034 SHALL verify the $0 guard: D Rs=0 while E.WAddr=0 with Tnew=3 -> all forward selects 0.
REQ-035 SHALL verify E forwarding: E.Rt=7, M {WAddr=7, Tnew=0} -> HIP_o_E_FwdRt=1. With M.WAddr=0 and W.WAddr=7 -> 2.
REQ-036 SHALL verify reset mid-stream: reset with all stages full -> next cycle every output is 0.
